// File: rtl/btb_assoc.sv
// btb_assoc: set-associative branch target buffer for the fetch stage.
//
// Each set holds WAYS entries of {valid, partial tag, 32-bit target} plus a
// round-robin victim pointer. A lookup is answered one cycle later from
// registered outputs. Updates from branch resolution allocate, overwrite or
// invalidate entries. flush_all clears every entry and every pointer.
//
// Optional feature macro: BTB_HYST_EN
//   When defined, each entry also carries a 2-bit saturating confidence
//   counter. A lookup hits only when counter bit 1 is set. A not-taken hit
//   invalidates the entry only once the counter drains to zero.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   lookup_valid/pc   lookup request (one accepted every cycle)
//   resp_valid/hit/target  registered response to previous cycle's lookup
//   upd_valid/pc/target/taken  resolved-branch update
//   flush_all         invalidate all entries (wins over a same-cycle update)
module btb_assoc #(
  parameter int SETS  = 16,
  parameter int WAYS  = 2,
  parameter int TAG_W = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_pc,
  output logic        resp_valid,
  output logic        resp_hit,
  output logic [31:0] resp_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  input  logic        flush_all
);

  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic             valid_q  [SETS][WAYS];
  logic [TAG_W-1:0] tag_q    [SETS][WAYS];
  logic [31:0]      target_q [SETS][WAYS];
  logic [WAY_W-1:0] rr_q     [SETS];
`ifdef BTB_HYST_EN
  logic [1:0]       ctr_q    [SETS][WAYS];
`endif

  logic        resp_valid_q, resp_hit_q;
  logic [31:0] resp_target_q;
  logic        resp_hit_d;
  logic [31:0] resp_target_d;

  // Only the index and tag fields of the PCs are used.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc, upd_pc};

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[IDX_W+2 +: TAG_W];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[IDX_W+2 +: TAG_W];

  // Lookup match per way; with hysteresis a weak entry does not predict.
  logic lk_match [WAYS];
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
`ifdef BTB_HYST_EN
      lk_match[w] = valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag) && ctr_q[lk_idx][w][1];
`else
      lk_match[w] = valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag);
`endif
    end
  end

  always_comb begin
    resp_hit_d    = 1'b0;
    resp_target_d = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (lk_match[w]) begin
        resp_hit_d    = 1'b1;
        resp_target_d = target_q[lk_idx][w];
      end
    end
  end

  // Update-side search: matching way (ignores confidence so no duplicate is
  // ever allocated) and the lowest-numbered free way.
  logic             up_hit, up_has_free;
  logic [WAY_W-1:0] up_hit_way, up_free_way, alloc_way, rr_next;
  always_comb begin
    up_hit      = 1'b0;
    up_hit_way  = '0;
    up_has_free = 1'b0;
    up_free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[up_idx][w]) begin
        up_has_free = 1'b1;
        up_free_way = WAY_W'(w);
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[up_idx][w] && (tag_q[up_idx][w] == up_tag)) begin
        up_hit     = 1'b1;
        up_hit_way = WAY_W'(w);
      end
    end
  end

  assign alloc_way = up_has_free ? up_free_way : rr_q[up_idx];
  assign rr_next   = (rr_q[up_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[up_idx] + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
        end
      end
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      resp_target_q <= '0;
    end else begin
      // The response always reflects state before this cycle's writes.
      resp_valid_q  <= lookup_valid;
      resp_hit_q    <= lookup_valid & resp_hit_d;
      resp_target_q <= lookup_valid ? resp_target_d : '0;

      if (flush_all) begin
        for (int s = 0; s < SETS; s++) begin
          rr_q[s] <= '0;
          for (int w = 0; w < WAYS; w++) begin
            valid_q[s][w] <= 1'b0;
          end
        end
      end else if (upd_valid) begin
        if (upd_taken) begin
          if (up_hit) begin
            target_q[up_idx][up_hit_way] <= upd_target;
`ifdef BTB_HYST_EN
            if (ctr_q[up_idx][up_hit_way] != 2'd3) begin
              ctr_q[up_idx][up_hit_way] <= ctr_q[up_idx][up_hit_way] + 2'd1;
            end
`endif
          end else begin
            valid_q[up_idx][alloc_way]  <= 1'b1;
            tag_q[up_idx][alloc_way]    <= up_tag;
            target_q[up_idx][alloc_way] <= upd_target;
`ifdef BTB_HYST_EN
            ctr_q[up_idx][alloc_way]    <= 2'd2;
`endif
            if (!up_has_free) begin
              rr_q[up_idx] <= rr_next;
            end
          end
        end else if (up_hit) begin
`ifdef BTB_HYST_EN
          // A valid entry never holds 0, so decrementing from 1 retires it.
          ctr_q[up_idx][up_hit_way] <= ctr_q[up_idx][up_hit_way] - 2'd1;
          if (ctr_q[up_idx][up_hit_way] == 2'd1) begin
            valid_q[up_idx][up_hit_way] <= 1'b0;
          end
`else
          valid_q[up_idx][up_hit_way] <= 1'b0;
`endif
        end
      end
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_hit    = resp_hit_q;
  assign resp_target = resp_target_q;

endmodule

// File: tb/tb_btb_assoc.sv
// tb_btb_assoc: directed scoreboard bench for btb_assoc (default parameters).
// Stimulus pushes the expected response for each cycle into a queue; a
// monitor on the falling edge pops one entry per cycle and compares it.
module tb_btb_assoc;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        resp_valid;
  logic        resp_hit;
  logic [31:0] resp_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        flush_all;

  int testsRun    = 0;
  int testsFailed = 0;
  bit running     = 1'b1;

  typedef struct {
    string       name;
    bit          v;
    bit          h;
    logic [31:0] t;
  } exp_t;

  exp_t expQ[$];

  always #5 clk = ~clk;

  btb_assoc dut (
    .clk          (clk),
    .rst          (rst),
    .lookup_valid (lookup_valid),
    .lookup_pc    (lookup_pc),
    .resp_valid   (resp_valid),
    .resp_hit     (resp_hit),
    .resp_target  (resp_target),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_target   (upd_target),
    .upd_taken    (upd_taken),
    .flush_all    (flush_all)
  );

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the response expected next cycle.
  task automatic applyStimulus(input bit r, input bit lv, input logic [31:0] lpc,
                               input bit uv, input logic [31:0] upc, input logic [31:0] utgt,
                               input bit utk, input bit fl,
                               input bit eh, input logic [31:0] et, input string nm);
    exp_t e;
    rst          = r;
    lookup_valid = lv;
    lookup_pc    = lpc;
    upd_valid    = uv;
    upd_pc       = upc;
    upd_target   = utgt;
    upd_taken    = utk;
    flush_all    = fl;
    @(posedge clk);
    #1;
    e.name = nm;
    e.v    = lv && !r;
    e.h    = e.v ? eh : 1'b0;
    e.t    = e.v ? et : 32'h0;
    expQ.push_back(e);
  endtask

  task automatic lookup(input logic [31:0] pc, input bit eh, input logic [31:0] et, input string nm);
    applyStimulus(0, 1, pc, 0, 0, 0, 0, 0, eh, et, nm);
  endtask

  task automatic update(input logic [31:0] pc, input logic [31:0] tgt, input bit tk);
    applyStimulus(0, 0, 0, 1, pc, tgt, tk, 0, 0, 0, "upd");
  endtask

  always @(negedge clk) begin
    if (running) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL scoreboard_underflow: got empty queue, expected an entry");
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput({e.name, ".valid"}, {31'b0, resp_valid}, {31'b0, e.v});
        if (e.v) begin
          checkOutput({e.name, ".hit"}, {31'b0, resp_hit}, {31'b0, e.h});
          checkOutput({e.name, ".target"}, resp_target, e.t);
        end
      end
    end
  end

  initial begin
    // Reset
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst0");
    applyStimulus(1, 1, 32'h1000, 0, 0, 0, 0, 0, 0, 0, "rst1");
    checkOutput("reset_valid", {31'b0, resp_valid}, 32'h0);
    checkOutput("reset_hit", {31'b0, resp_hit}, 32'h0);
    checkOutput("reset_target", resp_target, 32'h0);

    // Cold miss, then idle cycle has no response
    lookup(32'h1000, 0, 0, "s1_miss");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "s1_idle");

    // Allocate and hit
    update(32'h1004, 32'h2000, 1);
    lookup(32'h1004, 1, 32'h2000, "s2_hit");

    // Not-taken on a hit
    update(32'h1004, 0, 0);
    lookup(32'h1004, 0, 0, "s5_nt_miss");
    update(32'h1004, 32'h2000, 1);
    update(32'h1004, 32'h2000, 1);
    update(32'h1004, 0, 0);
`ifdef BTB_HYST_EN
    lookup(32'h1004, 1, 32'h2000, "s5_hyst_hit");
`else
    lookup(32'h1004, 0, 0, "s5_nt2_miss");
`endif
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "flush0");

    // Set 1 fill and round-robin eviction
    update(32'h1004, 32'hA000, 1);
    update(32'h2004, 32'hB000, 1);
    update(32'h3004, 32'hC000, 1);
    lookup(32'h1004, 0, 0, "s3_evicted1004");
    lookup(32'h2004, 1, 32'hB000, "s3_hit2004");
    lookup(32'h3004, 1, 32'hC000, "s3_hit3004");
    update(32'h4004, 32'hD000, 1);
    lookup(32'h2004, 0, 0, "s3_evicted2004");
    lookup(32'h4004, 1, 32'hD000, "s3_hit4004");
    update(32'h5004, 32'hE000, 1);
    lookup(32'h3004, 0, 0, "s3_evicted3004");
    lookup(32'h5004, 1, 32'hE000, "s3_hit5004");
    update(32'h4004, 32'hD100, 1);
    lookup(32'h4004, 1, 32'hD100, "s3_overwrite");
    update(32'h6004, 32'hF000, 1);
    lookup(32'h4004, 0, 0, "s3_rr_kept");
    lookup(32'h5004, 1, 32'hE000, "s3_hit5004b");

    // Read-before-write
    applyStimulus(0, 1, 32'h5008, 1, 32'h5008, 32'h7000, 1, 0, 0, 0, "s4_rbw_alloc");
    lookup(32'h5008, 1, 32'h7000, "s4_hit");
    applyStimulus(0, 1, 32'h5008, 1, 32'h5008, 0, 0, 0, 1, 32'h7000, "s4_rbw_nt");
    lookup(32'h5008, 0, 0, "s4_nt_miss");

    // Flush: leave set 1 with rr_ptr = 1, populate other sets
    update(32'h7004, 32'h7100, 1);
    update(32'h8004, 32'h8100, 1);
    update(32'h9004, 32'h9100, 1);
    update(32'h100C, 32'h300C, 1);
    update(32'h1010, 32'h3010, 1);
    update(32'h1014, 32'h3014, 1);
    update(32'h1018, 32'h3018, 1);
    lookup(32'h9004, 1, 32'h9100, "s6_pre9004");
    applyStimulus(0, 1, 32'h100C, 1, 32'h6004, 32'h6100, 1, 1, 1, 32'h300C, "s6_flush_lookup");
    lookup(32'h100C, 0, 0, "s6_flushed100C");
    lookup(32'h1010, 0, 0, "s6_flushed1010");
    lookup(32'h1014, 0, 0, "s6_flushed1014");
    lookup(32'h1018, 0, 0, "s6_flushed1018");
    lookup(32'h6004, 0, 0, "s6_dropped6004");
    update(32'h1004, 32'hA000, 1);
    update(32'h2004, 32'hB000, 1);
    update(32'h3004, 32'hC000, 1);
    lookup(32'h1004, 0, 0, "s6_rr_reset");
    lookup(32'h2004, 1, 32'hB000, "s6_hit2004");

    // Mid-operation reset drops the in-flight response and clears entries
    applyStimulus(1, 1, 32'h2004, 0, 0, 0, 0, 0, 0, 0, "rst_mid");
    lookup(32'h2004, 0, 0, "rst_cleared2004");
    lookup(32'h3004, 0, 0, "rst_cleared3004");

    @(negedge clk);
    #1;
    running = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
